reduce_engine: RTL and testbench
================================

# reduce_engine

Parametrised, multi-function reduction table for the collective router: it accumulates child contributions per tag through a shared, fixed-latency ALU pipeline. It emits one combined flit per completed reduction through a valid/ready output register. It sits between the router's reduce-input FIFO and the output arbiter. Compared with the single-function reduction table, it adds:

- a selectable combine function
- generic depth, width and latency
- input backpressure per busy entry
- output backpressure
- op-mismatch error reporting

## Interface
- PAYLOAD_W, 32, payload width in bits
- TAG_W, 4, tag width; table depth = 2^TAG_W entries
- CHILD_W, 3, width of the children count
- HDR_W, 44, opaque header bits (dst, src, rank, contextId, algtype) passed through unchanged
- ALU_LAT, 3, combine pipeline depth in cycles, ≥1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input flit present
- in_ready  out  1  input flit accepted this cycle when high together with in_valid
- in_tag  in  TAG_W  table index
- in_children  in  CHILD_W  number of children still to arrive after this flit
- in_func  in  3  combine function: 000 ADD, 001 MAX, 010 MIN, 011 AND, 100 OR, 101 XOR; 110/111 treated as ADD
- in_op  in  4  collective op code, stored and remapped on output
- in_hdr  in  HDR_W  passthrough header
- in_payload  in  PAYLOAD_W  operand
- out_valid  out  1  completed flit held
- out_ready  in  1  downstream accepts
- out_tag, out_op, out_hdr, out_payload  out  TAG_W/4/HDR_W/PAYLOAD_W  completed flit fields
- err_pulse  out  1  one-cycle pulse: function mismatch, flit dropped

## Operation
- Each entry holds: state (IDLE, ACCUM, BUSY, DONE), remaining count, function, op, header, and payload.
- `in_ready = (entry[in_tag].state ∈ {IDLE, ACCUM})`. The flag is combinational on `in_tag` and does not depend on `in_valid`.
- **Accept on IDLE entry:** store all fields and set `remaining = in_children`.
  - If `in_children == 0`, go to DONE (leaf case).
  - Otherwise go to ACCUM.
- **Accept on ACCUM entry, matching in_func:** issue (entry payload, in_payload, tag, func) into the ALU pipeline, decrement `remaining`, and go to BUSY.
- **Accept on ACCUM entry, different in_func:** drop the flit, assert err_pulse, and leave the entry unchanged.
- **Pipeline exit (ALU_LAT after issue):** write the result into the entry payload. Go to DONE if `remaining == 0`, else return to ACCUM.
- **Function arithmetic:**
  - ADD wraps modulo 2^PAYLOAD_W.
  - MAX and MIN compare two's-complement signed values.
  - AND, OR and XOR are bitwise.
- **Output arbitration:** round-robin over DONE entries, starting at `rr_ptr`.
  - The output register loads when it is empty, or when it is being drained this cycle (`out_valid && out_ready`).
  - On load, the chosen entry goes to IDLE and `rr_ptr` becomes the chosen index + 1, wrapping at 2^TAG_W.
- **Op remap on output:** 1101→1011 and 1111→1010; all other values pass unchanged. out_hdr, out_tag and out_payload are copied from the entry.
- **Simultaneous events:**
  - A pipeline writeback and a new accept never target the same entry, because BUSY blocks in_ready.
  - An output load and a new accept to the freed tag in the same cycle are not allowed: the entry is DONE during that cycle, so in_ready is low.
  - Accept, writeback and output load on three different entries proceed in the same cycle.

## Timing
- **Reset values:**
  - All entries IDLE; rr_ptr = 0.
  - Pipeline valids cleared.
  - out_valid = 0, out_* fields = 0, err_pulse = 0.
- Reset mid-operation discards all partial reductions and in-flight results, with no output.
- **Leaf:** accepted at edge N → entry DONE after N → out_valid high after edge N+1.
- **Combine:** issued at edge N → result written and state updated at edge N+ALU_LAT → in_ready for that tag high in the following cycle. If the combine completed the reduction, out_valid rises after edge N+ALU_LAT+1 at the earliest.
- **Throughput:** one accept per cycle across distinct tags. For a single tag, at most one combine every ALU_LAT+1 cycles.
- out_* fields are stable while `out_valid && !out_ready`. With `out_ready` held high, one flit is emitted per cycle.
- err_pulse is high for exactly the cycle after the offending accept edge.

## Test plan
- **Leaf:** tag 3, children 0, payload 0x1234, op 1101 → one flit with tag 3, payload 0x1234, op 1011, hdr unchanged, out_valid at cycle 2.
- **ADD of 4 contributions on tag 5:**
  - Stimulus: values 10, 20, 30, −5, with children 3/2/1/0, offered back-to-back.
  - Response: in_ready drops for ALU_LAT cycles after each combine; single output payload 55; wrap case 0xFFFFFFFF+2 → 1.
- **Function coverage:** MAX of {−3, 7}, MIN of {−3, 7}, AND/OR/XOR of {0xF0F0, 0x0FF0} → outputs 7, −3, 0x00F0, 0xFFF0, 0xFF00.
- **Mismatch:** ACCUM entry with ADD receives MAX → err_pulse for one cycle, entry payload and remaining unchanged, and the later matching flit completes normally.
- **Output backpressure and round-robin:**
  - Stimulus: tags 1, 2 and 7 become DONE while out_ready = 0 for 10 cycles, then out_ready = 1.
  - Response: outputs in order 1, 2, 7; each flit held stable while stalled; tags 1/2/7 re-accept only after their flit loads.
- **Reset mid-reduction:** assert rst while tag 4 is BUSY → no output; after reset, a leaf on tag 4 produces a fresh flit containing only the new payload.

Source files
------------

// File: rtl/reduce_engine.sv
// Per-tag reduction table: child flits are combined through a fixed ALU_LAT pipeline and one flit per tag leaves via a valid/ready register.
// in_ready is low while the tag's entry is BUSY or DONE; out_* hold steady while out_valid && !out_ready.
module reduce_engine #(
  parameter int PAYLOAD_W = 32,
  parameter int TAG_W     = 4,
  parameter int CHILD_W   = 3,
  parameter int HDR_W     = 44,
  parameter int ALU_LAT   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [CHILD_W-1:0]   in_children,
  input  logic [2:0]           in_func,
  input  logic [3:0]           in_op,
  input  logic [HDR_W-1:0]     in_hdr,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           out_op,
  output logic [HDR_W-1:0]     out_hdr,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 err_pulse
);

  localparam int DEPTH = 1 << TAG_W;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_BUSY, ST_DONE} ent_state_t;

  typedef struct packed {
    logic [CHILD_W-1:0]   remaining;
    logic [2:0]           func;
    logic [3:0]           op;
    logic [HDR_W-1:0]     hdr;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  ent_state_t state      [DEPTH];
  ent_state_t state_next [DEPTH];
  entry_t     ent        [DEPTH];

  logic                 pipe_vld [ALU_LAT];
  logic [TAG_W-1:0]     pipe_tag [ALU_LAT];
  logic [PAYLOAD_W-1:0] pipe_res [ALU_LAT];

  logic                 accept, accept_idle, issue, mismatch;
  logic                 wb_vld;
  logic [TAG_W-1:0]     wb_tag;
  logic [PAYLOAD_W-1:0] wb_res;
  logic [TAG_W-1:0]     rr_ptr, sel, probe;
  logic                 found, load;

  function automatic logic [PAYLOAD_W-1:0] combine(input logic [2:0] f,
                                                   input logic [PAYLOAD_W-1:0] a,
                                                   input logic [PAYLOAD_W-1:0] b);
    case (f)
      3'b001:  combine = ($signed(a) > $signed(b)) ? a : b;
      3'b010:  combine = ($signed(a) < $signed(b)) ? a : b;
      3'b011:  combine = a & b;
      3'b100:  combine = a | b;
      3'b101:  combine = a ^ b;
      default: combine = a + b;
    endcase
  endfunction

  function automatic logic [3:0] remap_op(input logic [3:0] op);
    case (op)
      4'b1101: remap_op = 4'b1011;
      4'b1111: remap_op = 4'b1010;
      default: remap_op = op;
    endcase
  endfunction

  assign in_ready    = (state[in_tag] == ST_IDLE) || (state[in_tag] == ST_ACCUM);
  assign accept      = in_valid && in_ready;
  assign accept_idle = accept && (state[in_tag] == ST_IDLE);
  assign issue       = accept && (state[in_tag] == ST_ACCUM) && (in_func == ent[in_tag].func);
  assign mismatch    = accept && (state[in_tag] == ST_ACCUM) && (in_func != ent[in_tag].func);

  assign wb_vld = pipe_vld[ALU_LAT-1];
  assign wb_tag = pipe_tag[ALU_LAT-1];
  assign wb_res = pipe_res[ALU_LAT-1];

  // The result is formed at issue and then delayed, so writeback lands exactly ALU_LAT edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ALU_LAT; i++) pipe_vld[i] <= 1'b0;
    end else begin
      pipe_vld[0] <= issue;
      for (int i = 1; i < ALU_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_tag[0] <= in_tag;
    pipe_res[0] <= combine(ent[in_tag].func, ent[in_tag].payload, in_payload);
    for (int i = 1; i < ALU_LAT; i++) begin
      pipe_tag[i] <= pipe_tag[i-1];
      pipe_res[i] <= pipe_res[i-1];
    end
  end

  // Round-robin search for the first DONE entry at or after rr_ptr.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    probe = '0;
    for (int i = 0; i < DEPTH; i++) begin
      probe = rr_ptr + TAG_W'(i);
      if (!found && (state[probe] == ST_DONE)) begin
        found = 1'b1;
        sel   = probe;
      end
    end
  end

  assign load = found && (!out_valid || out_ready);

  // Accept, writeback and load always address distinct entries, as each needs a different state.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) state_next[i] = state[i];
    if (accept_idle) state_next[in_tag] = (in_children == '0) ? ST_DONE : ST_ACCUM;
    if (issue)       state_next[in_tag] = ST_BUSY;
    if (wb_vld)      state_next[wb_tag] = (ent[wb_tag].remaining == '0) ? ST_DONE : ST_ACCUM;
    if (load)        state_next[sel]    = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) state[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < DEPTH; i++) state[i] <= state_next[i];
    end
  end

  // Entry contents need no reset: an entry is rewritten in full on its next IDLE accept.
  always_ff @(posedge clk) begin
    if (accept_idle) begin
      ent[in_tag] <= '{remaining: in_children, func: in_func, op: in_op,
                       hdr: in_hdr, payload: in_payload};
    end
    if (issue)  ent[in_tag].remaining <= ent[in_tag].remaining - CHILD_W'(1);
    if (wb_vld) ent[wb_tag].payload   <= wb_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      out_valid   <= 1'b0;
      out_tag     <= '0;
      out_op      <= '0;
      out_hdr     <= '0;
      out_payload <= '0;
      err_pulse   <= 1'b0;
    end else begin
      err_pulse <= mismatch;
      if (load) begin
        out_valid   <= 1'b1;
        out_tag     <= sel;
        out_op      <= remap_op(ent[sel].op);
        out_hdr     <= ent[sel].hdr;
        out_payload <= ent[sel].payload;
        rr_ptr      <= sel + TAG_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reduce_engine.sv
// Directed and randomized bench for reduce_engine; expected flits come from a per-tag fold of the
// contributions sent, with output flits collected at the falling edge.
module tb_reduce_engine;

  localparam int LAT = 3;

  typedef struct packed {
    logic [3:0]  tag;
    logic [3:0]  op;
    logic [43:0] hdr;
    logic [31:0] payload;
  } flit_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_tag;
  logic [2:0]  in_children;
  logic [2:0]  in_func;
  logic [3:0]  in_op;
  logic [43:0] in_hdr;
  logic [31:0] in_payload;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_tag;
  logic [3:0]  out_op;
  logic [43:0] out_hdr;
  logic [31:0] out_payload;
  logic        err_pulse;

  int    checks = 0;
  int    errors = 0;
  flit_t outq[$];

  reduce_engine #(.PAYLOAD_W(32), .TAG_W(4), .CHILD_W(3), .HDR_W(44), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_children(in_children),
    .in_func(in_func), .in_op(in_op), .in_hdr(in_hdr), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_op(out_op),
    .out_hdr(out_hdr), .out_payload(out_payload), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) outq.push_back('{out_tag, out_op, out_hdr, out_payload});
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'd1:    return (sa > sb) ? a : b;
      3'd2:    return (sa < sb) ? a : b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [3:0] ref_remap(input logic [3:0] op);
    if (op == 4'b1101) return 4'b1011;
    if (op == 4'b1111) return 4'b1010;
    return op;
  endfunction

  function automatic logic [43:0] rand_hdr();
    return {12'($urandom), 32'($urandom)};
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] tag, input logic [2:0] ch, input logic [2:0] f,
                      input logic [3:0] op, input logic [43:0] hdr, input logic [31:0] pl,
                      output int waits);
    in_tag = tag; in_children = ch; in_func = f; in_op = op; in_hdr = hdr; in_payload = pl;
    in_valid = 1'b1;
    waits = 0;
    #1;
    while (!in_ready && waits < 100) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 100) begin
      checks++;
      assert (in_ready === 1'b1) else begin
        errors++;
        $error("FAIL send_ready observed %b expected 1 for tag %0d", in_ready, tag);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_by_tag(input string name, input logic [3:0] tag, input logic [3:0] op,
                               input logic [43:0] hdr, input logic [31:0] pl);
    int    idx;
    int    cyc;
    flit_t f;
    idx = -1;
    cyc = 0;
    while (idx < 0 && cyc < 200) begin
      for (int i = 0; i < outq.size(); i++) if (idx < 0 && outq[i].tag == tag) idx = i;
      if (idx < 0) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    checks++;
    assert (idx >= 0) else begin
      errors++;
      $error("FAIL %s_seen observed none expected a flit for tag %0d", name, tag);
    end
    if (idx >= 0) begin
      f = outq[idx];
      outq.delete(idx);
      check({name, "_payload"}, 64'(f.payload), 64'(pl));
      check({name, "_op"}, 64'(f.op), 64'(op));
      check({name, "_hdr"}, 64'(f.hdr), 64'(hdr));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          w;
    logic [43:0] h;
    logic [43:0] hx[16];
    logic [31:0] fa[5];
    logic [31:0] fb[5];
    logic [31:0] fexp[5];
    logic [3:0]  fop[5];
    logic [3:0]  rtag[4];
    logic [2:0]  rfunc[4];
    logic [3:0]  rop[4];
    logic [43:0] rhdr[4];
    logic [31:0] rval[4][4];
    int          rk[4];
    int          rsent[4];
    int          left;
    int          j;
    bit          used[16];

    rst = 1'b1; in_valid = 1'b0; in_tag = '0; in_children = '0; in_func = '0;
    in_op = '0; in_hdr = '0; in_payload = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_err_pulse", 64'(err_pulse), 64'd0);
    check("rst_out_payload", 64'(out_payload), 64'd0);
    check("rst_out_hdr", 64'(out_hdr), 64'd0);
    check("rst_out_tag_op", 64'({out_tag, out_op}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    idle(1);

    // Leaf
    h = rand_hdr();
    send(4'd3, 3'd0, 3'd0, 4'b1101, h, 32'h1234, w);
    check("leaf_not_yet", 64'(out_valid), 64'd0);
    idle(1);
    check("leaf_valid", 64'(out_valid), 64'd1);
    expect_by_tag("leaf", 4'd3, 4'b1011, h, 32'h1234);

    // ADD of four contributions, back to back
    h = rand_hdr();
    send(4'd5, 3'd3, 3'd0, 4'b0011, h, 32'd10, w);
    send(4'd5, 3'd2, 3'd0, 4'b0000, rand_hdr(), 32'd20, w);
    check("add_first_combine_wait", 64'(w), 64'd0);
    send(4'd5, 3'd1, 3'd0, 4'b0000, rand_hdr(), 32'd30, w);
    check("add_busy_gap2", 64'(w), 64'(LAT));
    send(4'd5, 3'd0, 3'd0, 4'b0000, rand_hdr(), 32'hFFFF_FFFB, w);
    check("add_busy_gap3", 64'(w), 64'(LAT));
    expect_by_tag("add4", 4'd5, 4'b0011, h, 32'd55);
    idle(6);
    check("add_single_output", 64'(outq.size()), 64'd0);

    h = rand_hdr();
    send(4'd6, 3'd1, 3'd0, 4'b1111, h, 32'hFFFF_FFFF, w);
    send(4'd6, 3'd0, 3'd0, 4'b0000, rand_hdr(), 32'd2, w);
    expect_by_tag("add_wrap", 4'd6, 4'b1010, h, 32'd1);

    // MAX, MIN, AND, OR, XOR on tags 8..12
    fa   = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0};
    fb   = '{32'd7, 32'd7, 32'h0000_0FF0, 32'h0000_0FF0, 32'h0000_0FF0};
    fexp = '{32'd7, 32'hFFFF_FFFD, 32'h0000_00F0, 32'h0000_FFF0, 32'h0000_FF00};
    fop  = '{4'b1111, 4'b0001, 4'b1101, 4'b0110, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      hx[8+i] = rand_hdr();
      send(4'(8 + i), 3'd1, 3'(1 + i), fop[i], hx[8+i], fa[i], w);
    end
    for (int i = 0; i < 5; i++) send(4'(8 + i), 3'd0, 3'(1 + i), 4'b0000, rand_hdr(), fb[i], w);
    for (int i = 0; i < 5; i++)
      expect_by_tag($sformatf("func%0d", i + 1), 4'(8 + i), ref_remap(fop[i]), hx[8+i], fexp[i]);

    // Function mismatch on an ACCUM entry
    h = rand_hdr();
    send(4'd13, 3'd2, 3'd0, 4'b0101, h, 32'd100, w);
    send(4'd13, 3'd0, 3'd1, 4'b0000, rand_hdr(), 32'd999, w);
    check("mm_err_high", 64'(err_pulse), 64'd1);
    idle(1);
    check("mm_err_one_cycle", 64'(err_pulse), 64'd0);
    send(4'd13, 3'd0, 3'd0, 4'b0000, rand_hdr(), 32'd5, w);
    check("mm_entry_still_accum", 64'(w), 64'd0);
    idle(LAT + 3);
    check("mm_no_early_output", 64'(outq.size()), 64'd0);
    send(4'd13, 3'd0, 3'd0, 4'b0000, rand_hdr(), 32'd7, w);
    expect_by_tag("mm_complete", 4'd13, 4'b0101, h, 32'd112);

    // Output backpressure and round-robin order
    out_ready = 1'b0;
    hx[1] = rand_hdr(); hx[2] = rand_hdr(); hx[7] = rand_hdr();
    send(4'd1, 3'd0, 3'd0, 4'b0001, hx[1], 32'h101, w);
    send(4'd7, 3'd0, 3'd0, 4'b0111, hx[7], 32'h107, w);
    send(4'd2, 3'd0, 3'd0, 4'b0010, hx[2], 32'h102, w);
    idle(1);
    for (int c = 0; c < 10; c++) begin
      check("rr_hold_valid", 64'(out_valid), 64'd1);
      check("rr_hold_tag", 64'(out_tag), 64'd1);
      check("rr_hold_payload", 64'(out_payload), 64'h101);
      idle(1);
    end
    in_tag = 4'd1; #1;
    check("rr_tag1_ready_after_load", 64'(in_ready), 64'd1);
    in_tag = 4'd2; #1;
    check("rr_tag2_blocked", 64'(in_ready), 64'd0);
    in_tag = 4'd7; #1;
    check("rr_tag7_blocked", 64'(in_ready), 64'd0);
    idle(1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && outq.size() < 3; c++) idle(1);
    check("rr_count", 64'(outq.size()), 64'd3);
    if (outq.size() >= 3) begin
      check("rr_order0", 64'(outq[0].tag), 64'd1);
      check("rr_order1", 64'(outq[1].tag), 64'd2);
      check("rr_order2", 64'(outq[2].tag), 64'd7);
    end
    expect_by_tag("rr1", 4'd1, 4'b0001, hx[1], 32'h101);
    expect_by_tag("rr2", 4'd2, 4'b0010, hx[2], 32'h102);
    expect_by_tag("rr7", 4'd7, 4'b0111, hx[7], 32'h107);
    in_tag = 4'd2; #1;
    check("rr_tag2_ready_again", 64'(in_ready), 64'd1);
    idle(1);

    // Reset while tag 4 has a combine in flight
    send(4'd4, 3'd1, 3'd0, 4'b0000, rand_hdr(), 32'h111, w);
    send(4'd4, 3'd0, 3'd0, 4'b0000, rand_hdr(), 32'h222, w);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    in_tag = 4'd4; #1;
    check("rst_tag4_ready", 64'(in_ready), 64'd1);
    idle(LAT + 5);
    check("rst_no_output", 64'(outq.size()), 64'd0);
    check("rst_out_valid_low", 64'(out_valid), 64'd0);
    h = rand_hdr();
    send(4'd4, 3'd0, 3'd0, 4'b1001, h, 32'hABC, w);
    expect_by_tag("rst_fresh_leaf", 4'd4, 4'b1001, h, 32'hABC);

    // Randomized interleaved reductions on four distinct tags per round
    for (int r = 0; r < 4; r++) begin
      for (int t = 0; t < 16; t++) used[t] = 1'b0;
      left = 0;
      for (int i = 0; i < 4; i++) begin
        do rtag[i] = 4'($urandom_range(0, 15)); while (used[rtag[i]]);
        used[rtag[i]] = 1'b1;
        rk[i]    = $urandom_range(1, 4);
        rfunc[i] = 3'($urandom_range(0, 7));
        rop[i]   = 4'($urandom_range(0, 15));
        rhdr[i]  = rand_hdr();
        rsent[i] = 0;
        left += rk[i];
        for (int k = 0; k < 4; k++)
          rval[i][k] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
      end
      while (left > 0) begin
        j = $urandom_range(0, 3);
        if (rsent[j] < rk[j]) begin
          if (rsent[j] == 0)
            send(rtag[j], 3'(rk[j] - 1), rfunc[j], rop[j], rhdr[j], rval[j][0], w);
          else
            send(rtag[j], 3'($urandom_range(0, 7)), rfunc[j], 4'($urandom_range(0, 15)),
                 rand_hdr(), rval[j][rsent[j]], w);
          rsent[j]++;
          left--;
        end
      end
      for (int i = 0; i < 4; i++) begin
        logic [31:0] acc;
        acc = rval[i][0];
        for (int k = 1; k < rk[i]; k++) acc = ref_op(rfunc[i], acc, rval[i][k]);
        expect_by_tag($sformatf("rand_r%0d_t%0d", r, rtag[i]), rtag[i], ref_remap(rop[i]), rhdr[i], acc);
      end
    end

    idle(10);
    check("no_extra_flits", 64'(outq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
